// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester round-robin arbiter for a single data-RAM port.
// Latency: req seen in IDLE at cycle N -> ack at N+1 -> rdata valid from N+2.
// Backpressure: requesters hold req/we/addr/wdata until their one-cycle ack;
//   at most one access per two cycles.
// Ports: clock/reset (sync, active-high); per requester i: reqi, wei, addri,
//   wdatai in, acki, rdatai out; RAM side: mem_addr, mem_wval, mem_we out,
//   mem_rval in (combinational read).
// Optional: define MEM_ARB_LOCK_EN to add lock0/lock1 inputs and an owner
//   register that lets one requester keep the RAM across several accesses.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic                  ack0,
  output logic [DATA_WIDTH-1:0] rdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata1,
`ifdef MEM_ARB_LOCK_EN
  input  logic                  lock0,
  input  logic                  lock1,
`endif
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wval,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rval
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t state, state_nxt;
  logic   gnt, gnt_nxt;     // requester driving the RAM in ACCESS
  logic   prio, prio_nxt;   // winner of the next tie
  logic   we_sel;
  logic   mem_we_raw;

`ifdef MEM_ARB_LOCK_EN
  logic own_vld, own_vld_nxt;
  logic own_id, own_id_nxt;
  logic own_hold;           // owner still requesting: it alone is considered
  logic lock_sel;
  assign own_hold = own_vld && (own_id ? req1 : req0);
  assign lock_sel = gnt ? lock1 : lock0;
`endif

  assign we_sel = gnt ? we1 : we0;

  // A write must never reach the RAM during a reset cycle.
  assign mem_we = mem_we_raw & ~reset;

  always_comb begin
    state_nxt  = state;
    gnt_nxt    = gnt;
    prio_nxt   = prio;
    mem_addr   = '0;
    mem_wval   = '0;
    mem_we_raw = 1'b0;
    ack0       = 1'b0;
    ack1       = 1'b0;
`ifdef MEM_ARB_LOCK_EN
    own_vld_nxt = own_vld;
    own_id_nxt  = own_id;
`endif
    case (state)
      IDLE: begin
`ifdef MEM_ARB_LOCK_EN
        if (own_hold) begin
          // Locked: owner keeps the port, fairness pointer is frozen.
          state_nxt = ACCESS;
          gnt_nxt   = own_id;
        end else begin
          // Owner (if any) dropped its request: release and arbitrate now.
          own_vld_nxt = 1'b0;
          if (req0 | req1) begin
            state_nxt = ACCESS;
            gnt_nxt   = (req0 & req1) ? prio : req1;
            prio_nxt  = ~gnt_nxt;
          end
        end
`else
        if (req0 | req1) begin
          state_nxt = ACCESS;
          gnt_nxt   = (req0 & req1) ? prio : req1;
          prio_nxt  = ~gnt_nxt;
        end
`endif
      end
      ACCESS: begin
        state_nxt  = IDLE;
        mem_addr   = gnt ? addr1 : addr0;
        mem_wval   = gnt ? wdata1 : wdata0;
        mem_we_raw = we_sel;
        ack0       = ~gnt;
        ack1       = gnt;
`ifdef MEM_ARB_LOCK_EN
        own_vld_nxt = lock_sel;
        own_id_nxt  = gnt;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      gnt    <= 1'b0;
      prio   <= 1'b0;
      rdata0 <= '0;
      rdata1 <= '0;
`ifdef MEM_ARB_LOCK_EN
      own_vld <= 1'b0;
      own_id  <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      prio  <= prio_nxt;
`ifdef MEM_ARB_LOCK_EN
      own_vld <= own_vld_nxt;
      own_id  <= own_id_nxt;
`endif
      // Read data is captured only for the granted requester's reads.
      if (state == ACCESS && !we_sel) begin
        if (gnt) rdata1 <= mem_rval;
        else     rdata0 <= mem_rval;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a small RAM model.
// Inputs change 1 time unit after the rising edge; outputs sampled there too.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req0 = 0, we0 = 0, req1 = 0, we1 = 0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          ack0, ack1, mem_we;
  logic [DW-1:0] rdata0, rdata1, mem_wval, mem_rval;
  logic [AW-1:0] mem_addr;
`ifdef MEM_ARB_LOCK_EN
  logic          lock0 = 0, lock1 = 0;
`endif

  // RAM model, preloaded through a side write port.
  logic [DW-1:0] mem [0:255];
  logic          pre_we = 1'b0;
  logic [7:0]    pre_addr = '0;
  logic [DW-1:0] pre_dat = '0;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  assign mem_rval = mem[mem_addr[7:0]];
  always @(posedge clock) begin
    if (pre_we)      mem[pre_addr] <= pre_dat;
    else if (mem_we) mem[mem_addr[7:0]] <= mem_wval;
  end

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
`ifdef MEM_ARB_LOCK_EN
    .lock0(lock0), .lock1(lock1),
`endif
    .mem_addr(mem_addr), .mem_wval(mem_wval), .mem_we(mem_we), .mem_rval(mem_rval)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic poke(input logic [7:0] a, input logic [DW-1:0] d);
    pre_addr = a;
    pre_dat  = d;
    pre_we   = 1'b1;
    tick();
    pre_we   = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    // Reset state
    tick();
    check("rst_ack0", ack0, 0);
    check("rst_ack1", ack1, 0);
    check("rst_rdata0", rdata0, 0);
    check("rst_rdata1", rdata1, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    reset = 1'b0;

    // 1: single read by requester 0
    poke(8'h10, 32'hDEADBEEF);
    req0 = 1; we0 = 0; addr0 = 32'h10;
    tick();
    check("rd_ack0", ack0, 1);
    check("rd_ack1", ack1, 0);
    check("rd_addr", mem_addr, 32'h10);
    check("rd_we", mem_we, 0);
    tick();
    req0 = 0;
    check("rd_data0", rdata0, 32'hDEADBEEF);
    check("rd_ack0_off", ack0, 0);

    // 2: single write by requester 1, read back by requester 0
    req1 = 1; we1 = 1; addr1 = 32'h20; wdata1 = 32'h12345678;
    check("wr_we_pre", mem_we, 0);
    tick();
    check("wr_we", mem_we, 1);
    check("wr_ack1", ack1, 1);
    check("wr_ack0", ack0, 0);
    check("wr_addr", mem_addr, 32'h20);
    check("wr_wval", mem_wval, 32'h12345678);
    tick();
    req1 = 0; we1 = 0;
    check("wr_we_post", mem_we, 0);
    check("wr_mem", mem[8'h20], 32'h12345678);
    check("wr_rdata1_hold", rdata1, 0);
    req0 = 1; addr0 = 32'h20;
    tick();
    check("rb_ack0", ack0, 1);
    tick();
    req0 = 0;
    check("rb_data0", rdata0, 32'h12345678);

    // 3: tie after reset, then strict alternation
    poke(8'h50, 32'h5050);
    poke(8'h54, 32'h5454);
    do_reset();
    req0 = 1; addr0 = 32'h50; req1 = 1; addr1 = 32'h54;
    for (int i = 0; i < 9; i++) begin
      tick();
      check($sformatf("alt_ack0_%0d", i), ack0, (i % 2 == 0));
      check($sformatf("alt_ack1_%0d", i), ack1, (i % 2 == 1));
      tick();
      check($sformatf("alt_idle_%0d", i), {ack0, ack1}, 2'b00);
    end
    req0 = 0; req1 = 0;
    check("alt_rdata0", rdata0, 32'h5050);
    check("alt_rdata1", rdata1, 32'h5454);

    // 4: reset asserted in the ACCESS cycle of a write
    poke(8'h30, 32'h0BAD);
    req0 = 1; we0 = 1; addr0 = 32'h30; wdata0 = 32'hAAAA5555;
    tick();
    check("mr_addr", mem_addr, 32'h30);
    reset = 1;
    #1;
    check("mr_we", mem_we, 0);
    tick();
    check("mr_ack0", ack0, 0);
    check("mr_ack1", ack1, 0);
    check("mr_rdata0", rdata0, 0);
    check("mr_rdata1", rdata1, 0);
    check("mr_idle_addr", mem_addr, 0);
    check("mr_mem", mem[8'h30], 32'h0BAD);
    reset = 0; req0 = 0; we0 = 0;

    // 5: ungranted requester's rdata holds
    poke(8'h40, 32'h1);
    poke(8'h44, 32'h2);
    req1 = 1; addr1 = 32'h40;
    tick();
    check("hold_ack1", ack1, 1);
    tick();
    req1 = 0;
    check("hold_rdata1_a", rdata1, 32'h1);
    req0 = 1; addr0 = 32'h44;
    tick();
    check("hold_ack0", ack0, 1);
    check("hold_no_ack1", ack1, 0);
    tick();
    req0 = 0;
    check("hold_rdata0", rdata0, 32'h2);
    check("hold_rdata1_b", rdata1, 32'h1);

`ifdef MEM_ARB_LOCK_EN
    // 6: locked burst by requester 0 while requester 1 waits
    do_reset();
    req1 = 1; addr1 = 32'h40;
    req0 = 1; addr0 = 32'h44; lock0 = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("lk_ack0_%0d", i), ack0, 1);
      check($sformatf("lk_ack1_%0d", i), ack1, 0);
      tick();
      check($sformatf("lk_idle1_%0d", i), ack1, 0);
    end
    lock0 = 0;
    tick();
    check("lk_last_ack0", ack0, 1);
    check("lk_last_ack1", ack1, 0);
    req0 = 0;
    tick();
    check("lk_rel_idle", ack1, 0);
    tick();
    check("lk_ack1", ack1, 1);
    tick();
    req1 = 0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
